// File: rtl/fetch_if.sv
// Fetch-to-memory/decode/control bundle for the instruction fetch stage.
// The master side is the fetch stage itself; the slave side is memory, decode and control.
interface fetch_if #(
    parameter int ADDR_W = 10,
    parameter int INST_W = 16
);
    logic              fetch_en;
    logic [ADDR_W-1:0] inst_addr;
    logic [INST_W-1:0] inst;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              ir_valid;
    logic [INST_W-1:0] ir;
    logic [ADDR_W-1:0] ir_pc;
    logic              ir_ready;
    logic [15:0]       fetch_count;

    modport master (
        input  fetch_en, inst, redirect, redirect_pc, ir_ready,
        output inst_addr, ir_valid, ir, ir_pc, fetch_count
    );

    modport slave (
        output fetch_en, inst, redirect, redirect_pc, ir_ready,
        input  inst_addr, ir_valid, ir, ir_pc, fetch_count
    );
endinterface

// File: rtl/inst_fetch_stage.sv
// Instruction fetch stage: PC drives async-read instruction memory, the result is
// latched into the IR and offered to decode over valid/ready, with redirect and stall.
module inst_fetch_stage #(
    parameter int ADDR_W   = 10,
    parameter int INST_W   = 16,
    parameter int RESET_PC = 0
) (
    input  logic     clk,
    input  logic     rst_n,
    fetch_if.master  bus
);
    localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state_p1;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pc_p0;
    logic [ADDR_W-1:0] pc_nxt;
    logic [INST_W-1:0] ir_p1;
    logic [ADDR_W-1:0] ir_pc_p1;
    logic [15:0]       fetch_count_p1;
    logic              accept;
    logic              load;
    logic              capture;

    // Redirect outranks load; a handshake in a redirect cycle still counts.
    always_comb begin
        state_nxt = state_p1;
        pc_nxt    = pc_p0;
        capture   = 1'b0;
        accept    = (state_p1 == FULL) && bus.ir_ready;
        load      = bus.fetch_en && ((state_p1 == EMPTY) || bus.ir_ready);
        if (bus.redirect) begin
            state_nxt = EMPTY;
            pc_nxt    = bus.redirect_pc;
        end else if (load) begin
            state_nxt = FULL;
            pc_nxt    = pc_p0 + 1'b1;
            capture   = 1'b1;
        end else if (accept) begin
            state_nxt = EMPTY;
        end
    end

    // Stage p0 -> p1: PC presented to memory, returned word captured into the IR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p1       <= EMPTY;
            pc_p0          <= PC_RST;
            ir_p1          <= '0;
            ir_pc_p1       <= '0;
            fetch_count_p1 <= '0;
        end else begin
            state_p1 <= state_nxt;
            pc_p0    <= pc_nxt;
            if (capture) begin
                ir_p1    <= bus.inst;
                ir_pc_p1 <= pc_p0;
            end
            if (accept) begin
                fetch_count_p1 <= fetch_count_p1 + 16'd1;
            end
        end
    end

    assign bus.inst_addr   = pc_p0;
    assign bus.ir_valid    = (state_p1 == FULL);
    assign bus.ir          = ir_p1;
    assign bus.ir_pc       = ir_pc_p1;
    assign bus.fetch_count = fetch_count_p1;
endmodule

// File: doc/inst_fetch_stage.md
# inst_fetch_stage

Instruction fetch stage for the 16-bit multicycle/pipelined CPU, sitting directly between the program counter logic and the decoder. It drives a word address into the asynchronous-read instruction memory (1024 × 16), latches the returned instruction into an instruction register (IR) and hands it to decode over a valid/ready handshake. It also accepts PC redirects (jump/branch) from the control unit and supports stalling.

## Interface
- `ADDR_W`, default 10: instruction word-address width; the PC wraps modulo 2^ADDR_W.
- `INST_W`, default 16: instruction width.
- `RESET_PC`, default 0: PC value after reset.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fetch_en`  in  1  allows new fetches; when low, no new instruction enters the IR.
- `inst_addr`  out  ADDR_W  address to instruction memory; equals the PC register, purely registered.
- `inst`  in  INST_W  instruction returned by memory in the same cycle (combinational read).
- `redirect`  in  1  one-cycle pulse: load the PC from `redirect_pc` and flush the IR.
- `redirect_pc`  in  ADDR_W  redirect target.
- `ir_valid`  out  1  IR holds an instruction not yet accepted by decode.
- `ir`  out  INST_W  instruction register.
- `ir_pc`  out  ADDR_W  address the IR contents were fetched from.
- `ir_ready`  in  1  decode accepts the IR this cycle when `ir_valid` is also high.
- `fetch_count`  out  16  number of handshakes completed (`ir_valid && ir_ready`); wraps 0xFFFF→0.

## Operation
- Registers: `pc`, `ir`, `ir_pc`, `ir_valid`, `fetch_count`.
- Reset values: `pc=RESET_PC`, `ir=0`, `ir_pc=0`, `ir_valid=0`, `fetch_count=0`. Therefore `inst_addr=RESET_PC` during reset.
- Two-state control, held in `ir_valid`: EMPTY (0) and FULL (1).
- `load` = `fetch_en && (!ir_valid || ir_ready)`.
- Priority on each rising edge, highest first:
  - `redirect`: `pc<=redirect_pc`, `ir_valid<=0`, and `ir`/`ir_pc` hold. If `ir_valid && ir_ready` in that cycle, the handshake still counts as accepted.
  - `load`: `ir<=inst`, `ir_pc<=pc`, `ir_valid<=1`, `pc<=pc+1` (mod 2^ADDR_W).
  - `ir_valid && ir_ready && !fetch_en`: `ir_valid<=0`, with `pc` and `ir` held.
  - Otherwise all registers hold (stall). `ir`/`ir_pc` stay stable while `ir_valid && !ir_ready`.
- `fetch_count` increments on every cycle with `ir_valid && ir_ready`, regardless of `redirect` or `fetch_en`.
- Wrap-around: a fetch from `pc=1023` sets `pc=0`, with no flag and no stall.
- No opcode inspection: the block is ISA-agnostic, and decode or control raises `redirect`.

## Timing
- Fetch latency: with `fetch_en` high, the instruction at `pc` appears in `ir` with `ir_valid=1` one cycle after the edge on which `pc` was presented.
- First valid instruction: the first rising edge after `rst_n` deasserts, with `fetch_en=1`.
- Throughput: one instruction per cycle while `ir_ready=1`.
- Redirect penalty: exactly one bubble.
  - Edge N: `redirect` is sampled.
  - Cycle N+1: `inst_addr=redirect_pc` and `ir_valid=0`.
  - Edge N+2: `ir=mem[redirect_pc]` and `ir_valid=1`.
- Reset asserted mid-operation: all registers return to their reset values asynchronously, without waiting for a clock edge. Any in-flight instruction is discarded.
- `ir_ready` may be high while `ir_valid=0`; it has no effect in that case.

## Test plan
- Reset, then `fetch_en=1`, `ir_ready=1`, with memory `0:0xE500, 1:0x01F4, 2:0x8402` → on consecutive edges `ir`=0xE500/0x01F4/0x8402, `ir_pc`=0/1/2, and `fetch_count`=1,2,3 one cycle behind each.
- Stall: `ir_ready=0` for 3 cycles while `ir=0x01F4` is valid → `ir`, `ir_pc=1`, `ir_valid=1` and `pc=2` are all held. Raising `ir_ready` then yields `ir=0x8402` on the next edge, with no instruction lost or duplicated.
- Redirect: pulse `redirect`, `redirect_pc=21` while `ir_valid=1`, `ir_ready=1` → next cycle `ir_valid=0`, `inst_addr=21`, `fetch_count` incremented. The following edge gives `ir=mem[21]=0x45FE`, `ir_pc=21`.
- Wrap: `redirect_pc=1023` → `ir_pc=1023`, then `ir_pc=0` with `inst_addr=1` after the next fetch.
- `fetch_en=0` with a valid IR and `ir_ready=1` → `ir_valid` drops after one edge, then `pc` and `fetch_count` stay constant.
- Async reset asserted between edges mid-stream → `ir_valid`, `ir`, `fetch_count` go to 0 and `inst_addr` to `RESET_PC` immediately, before the next clock edge.
